sm_addsub_pipe: RTL and testbench
=================================

Name: sm_addsub_pipe

Overview:
- Parametrised, pipelined, multi-lane sign-magnitude adder/subtractor for the fixed-point vector datapath.
- Each lane uses this format: MSB is the sign, the low DATA_W-1 bits are the magnitude.
- Supersedes the single-lane 16-bit combinational subtract unit with these additions: add/sub mode, saturation, negative-zero normalisation, per-lane flags and a 2-stage valid/ready pipeline.
- Sits between the vector register read stage and writeback.

Parameters:
- DATA_W, 16, lane width in bits (sign + DATA_W-1 magnitude bits); must be >= 2.
- LANES, 4, number of independent lanes packed in one vector word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- op  in  1  0 = a+b, 1 = a-b; applies to all lanes.
- sat_en  in  1  1 = clamp magnitude overflow; 0 = wrap.
- a  in  LANES*DATA_W  operand A; lane i occupies bits [i*DATA_W +: DATA_W].
- b  in  LANES*DATA_W  operand B; same packing as a.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result beat.
- result  out  LANES*DATA_W  packed lane results.
- lane_zero  out  LANES  lane result is zero.
- lane_neg  out  LANES  lane result sign bit.
- lane_ovf  out  LANES  magnitude overflow occurred in the lane.
- any_ovf  out  1  OR of lane_ovf.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (ports clk, rst).
  - While rst=1 at a clk edge: both stage valid bits clear; result, lane_zero, lane_neg, lane_ovf and any_ovf clear to 0; out_valid=0.
  - in_ready=1 from the first cycle after reset is released.
  - Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Handshake:
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
  - out_valid, result and flags hold stable until the output transfer.
  - in_ready = ~s1_valid | s1_adv, where s1_adv = ~s2_valid | out_ready. in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid with no stall.
  - Throughput is 1 beat per cycle.
  - Beats stay in order; no drop or duplication under any out_ready pattern.
- Stage 1 (registered at input transfer), per lane:
  - Split each operand into sign and magnitude.
  - Effective B sign: eb = b_sign ^ op.
  - Register: eff_sub = a_sign ^ eb; mag_ge = |a| >= |b|; both magnitudes; a_sign; eb; sat_en.
- Stage 2 (registered when s1_adv), per lane:
  - Same signs: mag = |a| + |b| computed DATA_W bits wide; carry = bit DATA_W-1; sign = a_sign.
  - Different signs: mag = larger - smaller; sign = a_sign if |a| > |b|, eb if |b| > |a|; carry = 0.
  - Overflow: lane_ovf = carry.
    - sat_en=1: magnitude = all ones.
    - sat_en=0: magnitude = low DATA_W-1 bits (wrap).
  - Zero normalisation: if the final magnitude is 0, sign is forced to 0. There is no -0 output, including -0 operands and wrapped results.
  - lane_zero = (final magnitude == 0); lane_neg = final sign bit; any_ovf = |lane_ovf.
- Operand edge cases:
  - -0 inputs are treated as magnitude 0.
  - Equal magnitudes with differing effective signs give +0.

Decomposition:
- Package sm_pkg holds:
  - typedef sm_op_e {SM_ADD=1'b0, SM_SUB=1'b1};
  - a stage-1 per-lane struct (sign, eb, eff_sub, mag_ge, mag_a, mag_b);
  - constant functions mag_w(DATA_W) and mag_max(DATA_W).
- Sub-module sm_addsub_lane holds the per-lane combinational stage-1 decode and stage-2 resolve, instantiated LANES times.
- The top level owns the valid/ready control, pipeline registers and flag reduction.

Test Plan:
All cases use DATA_W=16, LANES=4 unless noted.

1. Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, result=0, flags=0 during reset; in_ready=1 in the cycle after release.
2. Basic add/sub: lane0 a=0x0005, b=0x8003, op=ADD -> 0x0002, neg=0, out_valid exactly 2 cycles after transfer. a=0x0003, b=0x0005, op=SUB -> 0x8002, neg=1.
3. Negative zero: a=0x8007, b=0x8007, SUB -> 0x0000, zero=1, neg=0. a=0x8000, b=0x0000, ADD -> 0x0000, neg=0.
4. Overflow: a=0x7FFF, b=0x0001, ADD, sat_en=0 -> 0x0000, ovf=1, zero=1, any_ovf=1. Same with sat_en=1 -> 0x7FFF. a=0xFFFF, b=0x0001, SUB, sat_en=1 -> 0xFFFF, ovf=1.
5. Backpressure: stream 6 distinct beats back-to-back; hold out_ready=0 on cycles 3-6 -> in_ready drops once both stages are full; all 6 results emerge in order, none lost or duplicated; result holds stable while stalled.
6. Reset mid-stream: assert rst with 2 beats in flight -> neither beat appears; the next beat after reset returns correctly. Also run with LANES=8, DATA_W=8: a=0x7F, b=0x01, ADD -> per-lane 0x00 with ovf=1 when sat_en=0.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared types and width helpers for the sign-magnitude add/sub pipeline.
package sm_pkg;

  typedef enum logic {
    SM_ADD = 1'b0,
    SM_SUB = 1'b1
  } sm_op_e;

  // Widest magnitude a lane may carry (DATA_W up to 64); narrower lanes leave the top bits zero.
  localparam int SM_MAG_W_MAX = 63;

  typedef struct packed {
    logic                    sign;
    logic                    eb;
    logic                    eff_sub;
    logic                    mag_ge;
    logic [SM_MAG_W_MAX-1:0] mag_a;
    logic [SM_MAG_W_MAX-1:0] mag_b;
  } sm_s1_t;

  function automatic int mag_w(input int data_w);
    return data_w - 1;
  endfunction

  function automatic logic [SM_MAG_W_MAX-1:0] mag_max(input int data_w);
    return (SM_MAG_W_MAX'(1) << mag_w(data_w)) - SM_MAG_W_MAX'(1);
  endfunction

endpackage

// File: rtl/sm_addsub_lane.sv
// One lane of the sign-magnitude add/sub: stage-1 operand decode and stage-2 resolve,
// both purely combinational; the parent owns the registers between them.
module sm_addsub_lane
  import sm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output sm_s1_t            s1_dec,
  input  sm_s1_t            s1_p1,
  input  logic              sat_p1,
  output logic [DATA_W-1:0] res,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  localparam int MW = mag_w(DATA_W);
  localparam logic [MW-1:0] MAG_MAX = MW'(mag_max(DATA_W));

  function automatic logic [MW-1:0] saturate(input logic [MW-1:0] mag,
                                             input logic          carry,
                                             input logic          sat);
    if (carry && sat) return MAG_MAX;
    return mag;
  endfunction

  // stage 1: split operands, fold op into the effective sign of b
  logic [MW-1:0] a_mag;
  logic [MW-1:0] b_mag;
  logic          eb;

  assign a_mag = a[MW-1:0];
  assign b_mag = b[MW-1:0];
  assign eb    = b[DATA_W-1] ^ (sm_op_e'(op) == SM_SUB);

  always_comb begin
    s1_dec         = '0;
    s1_dec.sign    = a[DATA_W-1];
    s1_dec.eb      = eb;
    s1_dec.eff_sub = a[DATA_W-1] ^ eb;
    s1_dec.mag_ge  = (a_mag >= b_mag);
    s1_dec.mag_a   = SM_MAG_W_MAX'(a_mag);
    s1_dec.mag_b   = SM_MAG_W_MAX'(b_mag);
  end

  // stage 2: magnitude add or subtract, overflow handling, -0 normalisation
  logic [MW-1:0]     ma;
  logic [MW-1:0]     mb;
  logic [DATA_W-1:0] sum;
  logic [MW-1:0]     diff;
  logic [MW-1:0]     mag_raw;
  logic [MW-1:0]     mag_fin;
  logic              carry;
  logic              sign_raw;
  logic              sign_fin;

  logic [2*SM_MAG_W_MAX-1:0] unused_mag_hi;
  assign unused_mag_hi = {s1_p1.mag_a, s1_p1.mag_b};

  assign ma = s1_p1.mag_a[MW-1:0];
  assign mb = s1_p1.mag_b[MW-1:0];

  always_comb begin
    sum      = {1'b0, ma} + {1'b0, mb};
    diff     = s1_p1.mag_ge ? (ma - mb) : (mb - ma);
    carry    = 1'b0;
    mag_raw  = diff;
    sign_raw = s1_p1.mag_ge ? s1_p1.sign : s1_p1.eb;
    if (!s1_p1.eff_sub) begin
      carry    = sum[DATA_W-1];
      mag_raw  = sum[MW-1:0];
      sign_raw = s1_p1.sign;
    end
    mag_fin  = saturate(mag_raw, carry, sat_p1);
    // a zero magnitude never carries a sign, whatever produced it
    sign_fin = sign_raw & (mag_fin != '0);
    res      = {sign_fin, mag_fin};
    zero     = (mag_fin == '0);
    neg      = sign_fin;
    ovf      = carry;
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Multi-lane sign-magnitude adder/subtractor with a two-stage valid/ready pipeline
// between vector register read and writeback.
module sm_addsub_pipe
  import sm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op,
  input  logic                    sat_en,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] result,
  output logic [LANES-1:0]        lane_zero,
  output logic [LANES-1:0]        lane_neg,
  output logic [LANES-1:0]        lane_ovf,
  output logic                    any_ovf
);

  logic   vld_p1;
  logic   vld_p2;
  logic   s1_adv;
  logic   in_fire;
  logic   sat_p1;
  sm_s1_t s1_dec [LANES];
  sm_s1_t s1_p1  [LANES];

  logic [LANES*DATA_W-1:0] res_nxt;
  logic [LANES-1:0]        zero_nxt;
  logic [LANES-1:0]        neg_nxt;
  logic [LANES-1:0]        ovf_nxt;

  // stage 2 drains whenever it is empty or the consumer takes it; stage 1 follows
  assign s1_adv    = ~vld_p2 | out_ready;
  assign in_ready  = ~vld_p1 | s1_adv;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_p2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sm_addsub_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .a     (a[i*DATA_W +: DATA_W]),
      .b     (b[i*DATA_W +: DATA_W]),
      .op    (op),
      .s1_dec(s1_dec[i]),
      .s1_p1 (s1_p1[i]),
      .sat_p1(sat_p1),
      .res   (res_nxt[i*DATA_W +: DATA_W]),
      .zero  (zero_nxt[i]),
      .neg   (neg_nxt[i]),
      .ovf   (ovf_nxt[i])
    );
  end

  // stage 1 boundary: decoded operands captured on input transfer
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int i = 0; i < LANES; i++) begin
        s1_p1[i] <= s1_dec[i];
      end
      sat_p1 <= sat_en;
    end
  end

  // stage 2 boundary: resolved lanes and flags, held until the output transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result    <= '0;
      lane_zero <= '0;
      lane_neg  <= '0;
      lane_ovf  <= '0;
      any_ovf   <= 1'b0;
    end else begin
      if (in_ready) begin
        vld_p1 <= in_valid;
      end
      if (s1_adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          result    <= res_nxt;
          lane_zero <= zero_nxt;
          lane_neg  <= neg_nxt;
          lane_ovf  <= ovf_nxt;
          any_ovf   <= |ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Bench for sm_addsub_pipe: constant vector table on lane 0, an arithmetic scoreboard
// on every lane, plus stall, mid-stream reset and an 8x8-bit configuration.
module tb_sm_addsub_pipe;
  import sm_pkg::*;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int W8 = 8;
  localparam int L8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid, in_ready, op, sat_en, out_valid, out_ready, any_ovf;
  logic [L*W-1:0] a, b, result;
  logic [L-1:0]   lane_zero, lane_neg, lane_ovf;

  logic             in_valid_8, in_ready_8, op_8, sat_8, out_valid_8, out_ready_8, any_ovf_8;
  logic [L8*W8-1:0] a_8, b_8, result_8;
  logic [L8-1:0]    lane_zero_8, lane_neg_8, lane_ovf_8;

  sm_addsub_pipe #(.DATA_W(W), .LANES(L)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .sat_en(sat_en), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .lane_zero(lane_zero), .lane_neg(lane_neg),
    .lane_ovf(lane_ovf), .any_ovf(any_ovf)
  );

  sm_addsub_pipe #(.DATA_W(W8), .LANES(L8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .op(op_8),
    .sat_en(sat_8), .a(a_8), .b(b_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .result(result_8), .lane_zero(lane_zero_8), .lane_neg(lane_neg_8),
    .lane_ovf(lane_ovf_8), .any_ovf(any_ovf_8)
  );

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  typedef struct {
    logic [L*W-1:0] res;
    logic [L-1:0]   z;
    logic [L-1:0]   n;
    logic [L-1:0]   o;
    logic           any;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        sat;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        o;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed-integer reference: value = +/-magnitude, op negates b, then clamp or wrap.
  function automatic void model_lane(input int w, input logic [63:0] av, input logic [63:0] bv,
                                     input logic opv, input logic satv, output logic [63:0] r,
                                     output logic z, output logic n, output logic o);
    int     mw;
    longint maxm, ma, mb, va, vb, s, m;
    logic   sa, sb, eb;
    mw   = w - 1;
    maxm = (longint'(1) << mw) - 1;
    ma   = longint'(av) & maxm;
    mb   = longint'(bv) & maxm;
    sa   = av[mw];
    sb   = bv[mw];
    eb   = sb ^ opv;
    va   = sa ? -ma : ma;
    vb   = eb ? -mb : mb;
    s    = va + vb;
    m    = (s < 0) ? -s : s;
    o    = (m > maxm);
    if (o) m = satv ? maxm : (m & maxm);
    n = (s < 0) && (m != 0);
    z = (m == 0);
    r = 64'(m);
    if (n) r[mw] = 1'b1;
  endfunction

  function automatic exp_t model_beat(input logic [L*W-1:0] av, input logic [L*W-1:0] bv,
                                      input logic opv, input logic satv);
    exp_t        e;
    logic [63:0] r;
    logic        z, n, o;
    e.res = '0; e.z = '0; e.n = '0; e.o = '0;
    for (int i = 0; i < L; i++) begin
      model_lane(W, 64'(av[i*W +: W]), 64'(bv[i*W +: W]), opv, satv, r, z, n, o);
      e.res[i*W +: W] = r[W-1:0];
      e.z[i] = z;
      e.n[i] = n;
      e.o[i] = o;
    end
    e.any = |e.o;
    return e;
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  exp_t           mon_e;
  logic           hold_v = 1'b0;
  logic [L*W-1:0] hold_res;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("stall_hold", 128'({out_valid, result}), 128'({1'b1, hold_res}));
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          check("sb_extra_beat", 128'(1), 128'(0));
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_beat", 128'({result, lane_zero, lane_neg, lane_ovf, any_ovf}),
                128'({mon_e.res, mon_e.z, mon_e.n, mon_e.o, mon_e.any}));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model_beat(a, b, op, sat_en));
      hold_v   = out_valid && !out_ready;
      hold_res = result;
    end
  end

  task automatic apply_vec(input vec_t v, input int idx);
    int n;
    @(posedge clk); #1;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    a[15:0] = v.a;
    b[15:0] = v.b;
    op = v.op; sat_en = v.sat; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("vec%0d_latency", idx), 128'(n), 128'(2));
    check($sformatf("vec%0d_lane0", idx), 128'({result[15:0], lane_zero[0], lane_neg[0], lane_ovf[0]}),
          128'({v.res, v.z, v.n, v.o}));
  endtask

  task automatic run8(input logic satv, input logic [L8*W8-1:0] exp_res, input logic [L8-1:0] exp_z);
    int n;
    @(posedge clk); #1;
    a_8 = {L8{8'h7F}}; b_8 = {L8{8'h01}}; op_8 = 1'b0; sat_8 = satv;
    in_valid_8 = 1'b1; out_ready_8 = 1'b1;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    n = 1;
    while (!out_valid_8 && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_latency", 128'(n), 128'(2));
    check("w8_result", 128'(result_8), 128'(exp_res));
    check("w8_ovf", 128'({lane_ovf_8, any_ovf_8}), 128'({8'hFF, 1'b1}));
    check("w8_zero_neg", 128'({lane_zero_8, lane_neg_8}), 128'({exp_z, 8'h00}));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [L*W-1:0] bp_a [6];
    logic [L*W-1:0] bp_b [6];
    int  k, n0;
    bit  saw_stall;

    vecs[0] = '{16'h0005, 16'h8003, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'h8002, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h8007, 16'h8007, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{16'h8004, 16'h0004, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'hFFFF, 16'h8001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{16'h0000, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};

    op = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
    a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
    in_valid_8 = 1'b0; op_8 = 1'b0; sat_8 = 1'b0; out_ready_8 = 1'b1; a_8 = '0; b_8 = '0;

    // Reset held two cycles with a beat offered.
    rst = 1'b1; in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_result", 128'(result), 128'(0));
      check("rst_flags", 128'({lane_zero, lane_neg, lane_ovf, any_ovf}), 128'(0));
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", 128'(in_ready), 128'(1));

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Six beats back-to-back with the consumer stalled on cycles 3-6.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = {$urandom(), $urandom()};
      bp_b[i] = {$urandom(), $urandom()};
    end
    k = 0; n0 = n_out; saw_stall = 1'b0;
    for (int cyc = 1; cyc <= 30 && (k < 6 || n_out - n0 < 6); cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (k < 6);
      if (k < 6) begin
        a = bp_a[k]; b = bp_b[k]; op = k[0]; sat_en = k[1];
      end
      @(negedge clk);
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) k++;
    end
    in_valid = 1'b0;
    check("bp_in_ready_dropped", 128'(saw_stall), 128'(1));
    check("bp_beats_out", 128'(n_out - n0), 128'(6));

    // Reset with two beats in flight and the output stalled.
    @(posedge clk); #1;
    n0 = n_out;
    out_ready = 1'b0; in_valid = 1'b1;
    a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
    @(posedge clk); #1;
    a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    check("rst_mid_out_valid", 128'(out_valid), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_beats", 128'(n_out - n0), 128'(0));
    apply_vec(vecs[1], 100);

    // Random traffic under random backpressure.
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      op = 1'($urandom_range(0, 1));
      sat_en = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 128'(sb_q.size()), 128'(0));

    run8(1'b0, '0, 8'hFF);
    run8(1'b1, {L8{8'h7F}}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
